decode_issue_stage: RTL and testbench

- Parametrised, pipelined successor to the combinational control decoder.
- Accepts 32-bit instructions over a valid/ready handshake and decodes opcode/fmt/funct into ALU and FPU control codes, a unit select and an illegal flag.
- Presents the decoded result from a registered output stage backed by a skid buffer.
- Enforces an issue lockout after long-latency FPU ops (divide, square root).
- Sits between instruction fetch and the ALU/FPU execute units.

---
 rtl/ctrl_pkg.sv | 76 +++++++
 rtl/pipe_skid_buf.sv | 83 ++++++++
 rtl/decode_issue_stage.sv | 88 ++++++++
 tb/tb_decode_issue_stage.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared decode definitions for the decode/issue stage: field encodings,
// unit select, control codes, the decoded bundle and the decode function.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000001;
    localparam logic [5:0] OP_ADDI  = 6'b000010;
    localparam logic [5:0] OP_JUMP  = 6'b000011;

    localparam logic [4:0] FMT_INT  = 5'b00001;
    localparam logic [4:0] FMT_FP   = 5'b00010;

    typedef enum logic [1:0] {
        UNIT_NONE = 2'd0,
        UNIT_ALU  = 2'd1,
        UNIT_FPU  = 2'd2,
        UNIT_JUMP = 2'd3
    } unit_sel_e;

    localparam logic [3:0] ALU_NOP  = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_JUMP = 4'b0010;

    localparam logic [3:0] FPU_NOP  = 4'b0000;
    localparam logic [3:0] FPU_DIV  = 4'b1101;
    localparam logic [3:0] FPU_SQRT = 4'b1110;

    typedef struct packed {
        unit_sel_e  unit;
        logic [3:0] alu_ctrl;
        logic [3:0] fpu_ctrl;
        logic       illegal;
        logic       fpu_long;
    } dec_bundle_t;

    // Every field not set by a legal encoding stays at zero.
    function automatic dec_bundle_t decode_instr(
        input logic [5:0] opcode,
        input logic [4:0] fmt,
        input logic [5:0] funct
    );
        dec_bundle_t b;
        b = '0;
        case (opcode)
            OP_RTYPE: begin
                if (fmt == FMT_INT && funct >= 6'd1 && funct <= 6'd9) begin
                    b.unit     = UNIT_ALU;
                    b.alu_ctrl = funct[3:0];
                end else if (fmt == FMT_FP && funct >= 6'd1 && funct <= 6'd5) begin
                    b.unit     = UNIT_FPU;
                    b.fpu_ctrl = funct[3:0];
                end else if (fmt == FMT_FP && funct >= 6'd7 && funct <= 6'd16) begin
                    // funct 6 is a hole in the FP space, so codes above it shift down by one
                    b.unit     = UNIT_FPU;
                    b.fpu_ctrl = 4'(funct - 6'd1);
                end else begin
                    b.illegal  = 1'b1;
                end
            end
            OP_ADDI: begin
                b.unit     = UNIT_ALU;
                b.alu_ctrl = ALU_ADD;
            end
            OP_JUMP: begin
                b.unit     = UNIT_JUMP;
                b.alu_ctrl = ALU_JUMP;
            end
            default: begin
                b.illegal  = 1'b1;
            end
        endcase
        b.fpu_long = (b.unit == UNIT_FPU) &&
                     (b.fpu_ctrl == FPU_DIV || b.fpu_ctrl == FPU_SQRT);
        return b;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-entry valid/ready skid buffer: an output register plus one
// skid entry. in_ready is registered, so there is no combinational path from
// out_ready to in_ready. stall hides the output entry without disturbing it.
module pipe_skid_buf #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    input  logic         stall
);

    logic         out_full;
    logic         skid_full;
    logic [W-1:0] out_q;
    logic [W-1:0] skid_q;
    logic         ready_q;

    logic         out_full_d;
    logic         skid_full_d;
    logic [W-1:0] out_d;
    logic [W-1:0] skid_d;

    logic         accept;
    logic         issue;

    assign accept    = in_valid && ready_q;
    assign out_valid = out_full && !stall;
    assign issue     = out_valid && out_ready;
    assign in_ready  = ready_q;
    assign out_data  = out_q;

    // Next occupancy: skid drains into the output register on issue; an
    // accept fills the output register unless it is held, then the skid.
    // Accept is impossible while skid is full because ready_q tracks it.
    always_comb begin
        out_full_d  = out_full;
        skid_full_d = skid_full;
        out_d       = out_q;
        skid_d      = skid_q;
        if (issue) begin
            if (skid_full) begin
                out_d       = skid_q;
                skid_full_d = 1'b0;
            end else if (accept) begin
                out_d       = in_data;
            end else begin
                out_full_d  = 1'b0;
            end
        end else if (accept) begin
            if (out_full) begin
                skid_d      = in_data;
                skid_full_d = 1'b1;
            end else begin
                out_d       = in_data;
                out_full_d  = 1'b1;
            end
        end
    end

    // Storage and registered ready; reset drops every held entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_full  <= 1'b0;
            skid_full <= 1'b0;
            out_q     <= '0;
            skid_q    <= '0;
            ready_q   <= 1'b0;
        end else begin
            out_full  <= out_full_d;
            skid_full <= skid_full_d;
            out_q     <= out_d;
            skid_q    <= skid_d;
            ready_q   <= !skid_full_d;
        end
    end

endmodule

// File: rtl/decode_issue_stage.sv
// Pipelined decode/issue stage: decodes instructions into ALU/FPU control
// bundles, buffers them in a skid buffer and holds issue off for a fixed
// number of cycles after a long-latency FPU op leaves the stage.
module decode_issue_stage #(
    parameter int unsigned INSTR_W      = 32,
    parameter int unsigned CTRL_W       = 4,
    parameter int unsigned FPU_LONG_LAT = 8,
    parameter int unsigned SKID_DEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instruction,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTRL_W-1:0]  alu_ctrl,
    output logic [CTRL_W-1:0]  fpu_ctrl,
    output logic [1:0]         unit_sel,
    output logic               illegal,
    output logic               fpu_long
);

    import ctrl_pkg::*;

    localparam int unsigned CNT_W    = (FPU_LONG_LAT > 1) ? $clog2(FPU_LONG_LAT) : 1;
    localparam int unsigned BUNDLE_W = $bits(dec_bundle_t);
    localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(FPU_LONG_LAT - 1);

    logic [5:0]          opcode;
    logic [4:0]          fmt;
    logic [5:0]          funct;
    logic                unused_fields;

    dec_bundle_t         dec_in;
    dec_bundle_t         dec_out;
    logic [BUNDLE_W-1:0] out_raw;

    logic [CNT_W-1:0]    lock_cnt;
    logic                stall;
    logic                issue_long;
    logic                unused_skid_depth;

    assign opcode        = instruction[INSTR_W-1 -: 6];
    assign fmt           = instruction[INSTR_W-7 -: 5];
    assign funct         = instruction[5:0];
    assign unused_fields = ^instruction[INSTR_W-12:6];
    assign unused_skid_depth = (SKID_DEPTH != 2);

    assign dec_in = decode_instr(opcode, fmt, funct);

    pipe_skid_buf #(
        .W (BUNDLE_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (dec_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_raw),
        .stall     (stall)
    );

    assign dec_out    = dec_bundle_t'(out_raw);
    assign stall      = (lock_cnt != '0);
    assign issue_long = out_valid && out_ready && dec_out.fpu_long;

    assign alu_ctrl = CTRL_W'(dec_out.alu_ctrl);
    assign fpu_ctrl = CTRL_W'(dec_out.fpu_ctrl);
    assign unit_sel = dec_out.unit;
    assign illegal  = dec_out.illegal;
    assign fpu_long = dec_out.fpu_long;

    // Lockout counter: loaded when a long FPU op issues, counts down to zero
    // while masking out_valid; a latency of one cycle never locks.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_cnt <= '0;
        end else if (issue_long && (FPU_LONG_LAT > 1)) begin
            lock_cnt <= LOCK_LOAD;
        end else if (stall) begin
            lock_cnt <= lock_cnt - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_decode_issue_stage.sv
// Scoreboard bench for decode_issue_stage: the driver queues the expected
// bundle at each accept, an independent monitor pops and compares on issue.
module tb_decode_issue_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_ctrl;
    logic [3:0]  fpu_ctrl;
    logic [1:0]  unit_sel;
    logic        illegal;
    logic        fpu_long;

    int          checks = 0;
    int          passes = 0;
    int          issued = 0;
    int          cyc = 0;
    int          last_issue_cyc = 0;
    int          last_long_cyc = 0;
    logic [11:0] expq[$];

    localparam logic [1:0] U_NONE = 2'd0;
    localparam logic [1:0] U_ALU  = 2'd1;
    localparam logic [1:0] U_FPU  = 2'd2;
    localparam logic [1:0] U_JUMP = 2'd3;

    decode_issue_stage #(
        .INSTR_W      (32),
        .CTRL_W       (4),
        .FPU_LONG_LAT (8),
        .SKID_DEPTH   (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instruction (instruction),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_ctrl    (alu_ctrl),
        .fpu_ctrl    (fpu_ctrl),
        .unit_sel    (unit_sel),
        .illegal     (illegal),
        .fpu_long    (fpu_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] eb(input logic [1:0] u, input logic [3:0] a,
                                       input logic [3:0] f, input logic i, input logic l);
        return {u, a, f, i, l};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Drive one instruction until accepted; queue its expected bundle.
    task automatic send(input logic [31:0] ins, input logic [11:0] e);
        int unsigned n;
        bit done;
        n = 0;
        done = 1'b0;
        in_valid = 1'b1;
        instruction = ins;
        while (!done && n < 100) begin
            @(negedge clk);
            if (in_ready) begin
                expq.push_back(e);
                done = 1'b1;
            end
            n++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            $display("FAIL send_timeout: instruction 0x%08h not accepted in %0d cycles, expected acceptance", ins, n);
        end
    endtask

    task automatic wait_drain(input string name);
        int unsigned n;
        n = 0;
        while (expq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (expq.size() == 0) passes++;
        else $display("FAIL %s: %0d bundles still pending, expected 0", name, expq.size());
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every issued bundle against the scoreboard head.
    initial begin
        logic [11:0] e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                issued++;
                last_issue_cyc = cyc;
                if (expq.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_issue: got bundle 0x%03h expected no issue",
                             {unit_sel, alu_ctrl, fpu_ctrl, illegal, fpu_long});
                end else begin
                    e = expq.pop_front();
                    if (e[0]) last_long_cyc = cyc;
                    check("bundle", {20'd0, unit_sel, alu_ctrl, fpu_ctrl, illegal, fpu_long}, {20'd0, e});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] fexp [1:16];
        int          base_issued;

        fexp[1]  = eb(U_FPU,  4'd0, 4'd1,  1'b0, 1'b0);
        fexp[2]  = eb(U_FPU,  4'd0, 4'd2,  1'b0, 1'b0);
        fexp[3]  = eb(U_FPU,  4'd0, 4'd3,  1'b0, 1'b0);
        fexp[4]  = eb(U_FPU,  4'd0, 4'd4,  1'b0, 1'b0);
        fexp[5]  = eb(U_FPU,  4'd0, 4'd5,  1'b0, 1'b0);
        fexp[6]  = eb(U_NONE, 4'd0, 4'd0,  1'b1, 1'b0);
        fexp[7]  = eb(U_FPU,  4'd0, 4'd6,  1'b0, 1'b0);
        fexp[8]  = eb(U_FPU,  4'd0, 4'd7,  1'b0, 1'b0);
        fexp[9]  = eb(U_FPU,  4'd0, 4'd8,  1'b0, 1'b0);
        fexp[10] = eb(U_FPU,  4'd0, 4'd9,  1'b0, 1'b0);
        fexp[11] = eb(U_FPU,  4'd0, 4'd10, 1'b0, 1'b0);
        fexp[12] = eb(U_FPU,  4'd0, 4'd11, 1'b0, 1'b0);
        fexp[13] = eb(U_FPU,  4'd0, 4'd12, 1'b0, 1'b0);
        fexp[14] = eb(U_FPU,  4'd0, 4'd13, 1'b0, 1'b1);
        fexp[15] = eb(U_FPU,  4'd0, 4'd14, 1'b0, 1'b1);
        fexp[16] = eb(U_FPU,  4'd0, 4'd15, 1'b0, 1'b0);

        rst = 1'b1;
        in_valid = 1'b0;
        instruction = '0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_ctrls", {20'd0, unit_sel, alu_ctrl, fpu_ctrl, illegal, fpu_long}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_rst", {31'd0, in_ready}, 32'd1);

        // Basic ALU decode with one-cycle latency
        out_ready = 1'b1;
        send(32'h04200001, eb(U_ALU, 4'd1, 4'd0, 1'b0, 1'b0));
        check("latency_valid", {31'd0, out_valid}, 32'd1);
        wait_drain("drain_basic");

        // FPU funct sweep, back to back
        for (int f = 1; f <= 16; f++) begin
            send(32'h04400000 | f, fexp[f]);
        end
        wait_drain("drain_fpu_sweep");

        // Other opcodes, boundaries and illegal encodings
        send(32'hFC000000, eb(U_NONE, 4'd0, 4'd0, 1'b1, 1'b0));
        send(32'h0800FFFF, eb(U_ALU,  4'd1, 4'd0, 1'b0, 1'b0));
        send(32'h0C000000, eb(U_JUMP, 4'd2, 4'd0, 1'b0, 1'b0));
        send(32'h04200009, eb(U_ALU,  4'd9, 4'd0, 1'b0, 1'b0));
        send(32'h0420000A, eb(U_NONE, 4'd0, 4'd0, 1'b1, 1'b0));
        send(32'h04200000, eb(U_NONE, 4'd0, 4'd0, 1'b1, 1'b0));
        send(32'h04400000, eb(U_NONE, 4'd0, 4'd0, 1'b1, 1'b0));
        send(32'h04400011, eb(U_NONE, 4'd0, 4'd0, 1'b1, 1'b0));
        send(32'h04600001, eb(U_NONE, 4'd0, 4'd0, 1'b1, 1'b0));
        wait_drain("drain_misc");

        // Backpressure: two captured, third blocked, order kept on release
        base_issued = issued;
        out_ready = 1'b0;
        send(32'h04200003, eb(U_ALU,  4'd3, 4'd0, 1'b0, 1'b0));
        send(32'h0C000000, eb(U_JUMP, 4'd2, 4'd0, 1'b0, 1'b0));
        check("skid_full_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b1;
        instruction = 32'h04400002;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("third_blocked", {31'd0, in_ready}, 32'd0);
            check("held_stable", {20'd0, unit_sel, alu_ctrl, fpu_ctrl, illegal, fpu_long},
                  {20'd0, eb(U_ALU, 4'd3, 4'd0, 1'b0, 1'b0)});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(32'h04400002, eb(U_FPU, 4'd0, 4'd2, 1'b0, 1'b0));
        wait_drain("drain_backpressure");
        check("bp_issue_count", issued - base_issued, 32'd3);

        // Lockout after FPU divide
        send(32'h0440000E, eb(U_FPU, 4'd0, 4'd13, 1'b0, 1'b1));
        send(32'h04200001, eb(U_ALU, 4'd1, 4'd0,  1'b0, 1'b0));
        repeat (3) @(posedge clk);
        #1;
        check("ready_in_lockout", {31'd0, in_ready}, 32'd1);
        check("lockout_masks_valid", {31'd0, out_valid}, 32'd0);
        wait_drain("drain_lockout");
        check("lockout_gap", last_issue_cyc - last_long_cyc, 32'd8);

        // Reset with skid full and lockout running
        send(32'h0440000F, eb(U_FPU, 4'd0, 4'd14, 1'b0, 1'b1));
        send(32'h04200002, eb(U_ALU, 4'd2, 4'd0,  1'b0, 1'b0));
        send(32'h04200004, eb(U_ALU, 4'd4, 4'd0,  1'b0, 1'b0));
        check("skid_full_in_lockout", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        expq.delete();
        @(posedge clk);
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        check("midrst_ctrls", {20'd0, unit_sel, alu_ctrl, fpu_ctrl, illegal, fpu_long}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_midrst", {31'd0, in_ready}, 32'd1);
        send(32'h08000000, eb(U_ALU, 4'd1, 4'd0, 1'b0, 1'b0));
        check("post_rst_no_lockout", {31'd0, out_valid}, 32'd1);
        wait_drain("drain_post_rst");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
